// File: rtl/imm_narrow_pkg.sv
// rtl/imm_narrow_pkg.sv - shared constants and skid state type for the immediate narrower
package imm_narrow_pkg;

    localparam int IMM_W  = 2;
    localparam int DATA_W = 8;

    // Two's-complement extremes of the narrowed immediate field.
    localparam logic [IMM_W-1:0] IMM_MIN = 2'b10;
    localparam logic [IMM_W-1:0] IMM_MAX = 2'b01;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

endpackage

// File: rtl/imm_range_check.sv
// rtl/imm_range_check.sv - combinational signed range check, clamp or wrap to OUT_W bits
//
// Ports:
//   data  in   IN_W   signed value to narrow
//   imm   out  OUT_W  narrowed signed immediate
//   ovf   out  1      data was outside the OUT_W signed range
module imm_range_check #(
    parameter int IN_W     = 8,
    parameter int OUT_W    = 2,
    parameter bit SATURATE = 1'b1
) (
    input  logic [IN_W-1:0]  data,
    output logic [OUT_W-1:0] imm,
    output logic             ovf
);

    localparam logic [OUT_W-1:0] MIN_V = {1'b1, {(OUT_W-1){1'b0}}};
    localparam logic [OUT_W-1:0] MAX_V = {1'b0, {(OUT_W-1){1'b1}}};

    logic [IN_W-OUT_W:0] upper;
    logic                fits;

    // The value fits when every bit from the MSB down to the narrowed sign
    // bit is a copy of the sign.
    assign upper = data[IN_W-1:OUT_W-1];
    assign fits  = (&upper) | ~(|upper);

    always_comb begin
        imm = data[OUT_W-1:0];
        ovf = 1'b0;
        if (!fits) begin
            ovf = 1'b1;
            if (SATURATE) begin
                imm = data[IN_W-1] ? MIN_V : MAX_V;
            end
        end
    end

endmodule

// File: rtl/imm_narrow.sv
// rtl/imm_narrow.sv - 8-to-2-bit signed immediate narrower with skid buffer and overflow count
//
// Ports:
//   clk        in   1      system clock, rising edge
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      producer has a value
//   in_ready   out  1      block can accept (registered)
//   in_data    in   IN_W   signed value to narrow
//   out_valid  out  1      narrowed item available
//   out_ready  in   1      consumer accepts
//   out_imm    out  OUT_W  narrowed signed immediate
//   out_ovf    out  1      item was out of range
//   clr_count  in   1      synchronous clear of ovf_count
//   ovf_count  out  CNT_W  saturating count of accepted overflowing items
module imm_narrow
    import imm_narrow_pkg::*;
#(
    parameter int IN_W     = DATA_W,
    parameter int OUT_W    = IMM_W,
    parameter bit SATURATE = 1'b1,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_imm,
    output logic             out_ovf,
    input  logic             clr_count,
    output logic [CNT_W-1:0] ovf_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [OUT_W-1:0] chk_imm;
    logic             chk_ovf;

    imm_range_check #(
        .IN_W     (IN_W),
        .OUT_W    (OUT_W),
        .SATURATE (SATURATE)
    ) u_range_check (
        .data (in_data),
        .imm  (chk_imm),
        .ovf  (chk_ovf)
    );

    skid_state_t      state, state_next;
    logic [OUT_W-1:0] main_imm, skid_imm;
    logic             main_ovf, skid_ovf;
    logic             accept;
    logic             load_main_in, load_main_skid, load_skid;

    assign accept    = in_valid & in_ready;
    assign out_valid = (state != EMPTY);
    assign out_imm   = main_imm;
    assign out_ovf   = main_ovf;

    always_comb begin
        state_next     = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state)
            EMPTY: begin
                if (accept) begin
                    state_next   = ONE;
                    load_main_in = 1'b1;
                end
            end
            ONE: begin
                if (accept && out_ready) begin
                    load_main_in = 1'b1;
                end else if (accept) begin
                    // Consumer stalled: park the new item behind the head.
                    state_next = FULL;
                    load_skid  = 1'b1;
                end else if (out_ready) begin
                    state_next = EMPTY;
                end
            end
            FULL: begin
                if (out_ready) begin
                    state_next     = ONE;
                    load_main_skid = 1'b1;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= EMPTY;
            in_ready <= 1'b1;
            main_imm <= '0;
            main_ovf <= 1'b0;
            skid_imm <= '0;
            skid_ovf <= 1'b0;
        end else begin
            state    <= state_next;
            // Registered ready: look ahead at the next state so a full buffer
            // is never offered another item.
            in_ready <= (state_next != FULL);
            if (load_main_in) begin
                main_imm <= chk_imm;
                main_ovf <= chk_ovf;
            end else if (load_main_skid) begin
                main_imm <= skid_imm;
                main_ovf <= skid_ovf;
            end
            if (load_skid) begin
                skid_imm <= chk_imm;
                skid_ovf <= chk_ovf;
            end
        end
    end

    // Clear takes priority, but an overflow accepted in the same cycle still counts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_count <= '0;
        end else if (clr_count) begin
            ovf_count <= (accept && chk_ovf) ? CNT_ONE : '0;
        end else if (accept && chk_ovf && (ovf_count != CNT_MAX)) begin
            ovf_count <= ovf_count + CNT_ONE;
        end
    end

endmodule
